out_unit: RTL and testbench
===========================

Name: out_unit

Overview:
- Execution unit for dispatch class 9 (Out).
- Accepts out-instruction operands from the dispatch stage over a valid/ready handshake and buffers the low byte of each in a FIFO.
- Serializes buffered bytes onto a UART TX line: 8N1, LSB first.
- Reports idle status so the pipeline can drain output before halting.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 16: byte FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- dispatch_valid  input  1  dispatch presents an out operation
- dispatch_ready  output  1  unit can accept an operation this cycle
- dispatch_data  input  32  rs1 value; only bits [7:0] are transmitted
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of buffered bytes not yet popped
- tx_idle  output  1  FIFO empty and transmitter in IDLE
- txd  output  1  UART serial output, registered

Behaviour:
- Reset: synchronous, active-high, on a rising edge with rst=1.
  - Clears FIFO pointers; fifo_count=0.
  - State -> IDLE; baud counter=0; bit index=0.
  - txd=1, dispatch_ready=1, tx_idle=1.
- Handshake:
  - dispatch_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - Accept occurs on an edge where dispatch_valid & dispatch_ready; dispatch_data[7:0] is written at the write pointer.
  - No full-bypass: when full, ready stays 0 even if a pop happens that cycle.
  - No empty-bypass: every byte passes through the FIFO.
  - Upper 24 bits of dispatch_data are ignored.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pop happens only inside the TX FSM, as described below.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If FIFO non-empty at an edge: pop head into an 8-bit shift register, counter=0, go to START.
  - txd=0 is driven from that same edge.
- START:
  - txd=0 for CLKS_PER_BIT cycles.
  - When counter == CLKS_PER_BIT-1: counter=0, bit index=0, go to DATA, txd=shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At counter end: shift right, bit index+1.
  - After bit index 7 completes: go to STOP, txd=1.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - At counter end with FIFO non-empty: pop and go straight to START, txd=0. No idle gap between frames.
  - At counter end with FIFO empty: go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Accept on edge N into an empty FIFO in IDLE: pop at edge N+1; txd falls at edge N+1.
- tx_idle = (state == IDLE) & (fifo_count == 0). It deasserts on the accept edge and reasserts on the edge where STOP ends with the FIFO empty.
- Reset mid-frame: current frame is truncated, txd=1 after the reset edge, and buffered bytes are discarded.
- dispatch_valid with X data while ready=0 has no effect.

Test Plan:
- Reset: hold rst 2 cycles -> txd=1, dispatch_ready=1, fifo_count=0, tx_idle=1; all remain stable for 100 cycles with no valid.
- Single byte: CLKS_PER_BIT=4, accept 0x000000A5.
  - txd falls 1 edge after the accept.
  - Bit sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_idle returns to 1 exactly 40 cycles after txd falls.
- Upper bits ignored: accept 0xDEADBE41 -> serialized data bits 1,0,0,0,0,0,1,0 (0x41).
- Back-to-back: accept 0x00 then 0xFF on consecutive cycles.
  - Stop bit of frame 1 is followed immediately by the start bit of frame 2 (80 cycles total, no gap).
  - fifo_count sequence: 1, 1, 0.
- Full FIFO: FIFO_DEPTH=16, assert valid every cycle with bytes 0..20.
  - Byte 0 is popped, then bytes 1..16 fill the FIFO; ready drops with fifo_count=16 while byte 17 waits.
  - Byte 17 is accepted on the edge after the pop that ends frame 0's stop bit.
  - Output byte order is 0, 1, 2, ... with no loss or duplication.
- Reset mid-frame: assert rst during DATA bit 3 with 5 bytes buffered -> txd=1 and fifo_count=0 after the edge; the next accepted byte 0x3C transmits as a clean full frame.

Source files
------------

// File: rtl/out_unit.sv
// out_unit: execution unit for "out" instructions.
// Buffers the low byte of each dispatched operand in a FIFO and serializes
// the bytes onto an 8N1 UART TX line, LSB first. Frames sent back-to-back
// have no idle gap between them.
module out_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    input  logic [31:0]                   dispatch_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_idle,
    output logic                          txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            txd_q;

    logic            push, pop, fifo_empty, cnt_end;
    logic [7:0]      head;

    // Only the low byte is transmitted; the rest of the operand is dropped.
    logic unused_data;
    assign unused_data = ^dispatch_data[31:8];

    assign fifo_empty     = (count_q == '0);
    assign dispatch_ready = (count_q != FULL_CNT);
    assign push           = dispatch_valid & dispatch_ready;
    assign cnt_end        = (cnt_q == CNT_LAST);
    assign head           = mem_q[rd_ptr_q];
    // The FIFO is popped only when the FSM starts a frame: from IDLE, or
    // right at the end of a stop bit so the next start bit follows with no gap.
    assign pop            = !fifo_empty &&
                            ((state_q == S_IDLE) || (state_q == S_STOP && cnt_end));

    assign fifo_count = count_q;
    assign tx_idle    = (state_q == S_IDLE) && fifo_empty;
    assign txd        = txd_q;

    // Occupancy next-state: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= dispatch_data[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // TX FSM with a registered txd; every state lasts CLKS_PER_BIT cycles per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        cnt_q   <= '0;
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            state_q <= S_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_unit.sv
// tb_out_unit: directed stimulus with a scoreboard. The driver pushes each
// expected byte into exp_q; a UART-receiver monitor decodes frames from txd
// and pops/compares independently.
module tb_out_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dispatch_valid = 1'b0;
    logic [31:0] dispatch_data = '0;
    logic        dispatch_ready;
    logic [4:0]  fifo_count;
    logic        tx_idle;
    logic        txd;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    out_unit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_data  (dispatch_data),
        .fifo_count     (fifo_count),
        .tx_idle        (tx_idle),
        .txd            (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (tx_idle !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("wait_idle", tx_idle, 1);
    endtask

    // Monitor: UART receiver sampling on the falling clock edge.
    initial begin : mon
        logic        last;
        logic [39:0] smp;
        logic        ab, ok;
        logic [7:0]  b;
        last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 1'b0;
            end else if (last === 1'b1 && txd === 1'b0) begin
                starts.push_back(cyc);
                smp = '0;
                ab  = 1'b0;
                for (int s = 1; s < 40; s++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    smp[s] = txd;
                end
                if (ab) begin
                    last = 1'b0;
                end else begin
                    ok = (smp[3:0] == 4'b0000) && (smp[39:36] == 4'hF);
                    for (int k = 0; k < 8; k++) begin
                        b[k] = smp[4+4*k];
                        if (smp[4+4*k +: 4] != {4{b[k]}}) ok = 1'b0;
                    end
                    chk("frame_shape", ok, 1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rx_unexpected: got %0h expected no frame", b);
                    end else begin
                        chk("rx_byte", b, exp_q.pop_front());
                    end
                    last = smp[39];
                end
            end else begin
                last = txd;
            end
        end
    end

    // Driver
    initial begin : drv
        int n, w, c0, c17;
        c0 = 0;
        c17 = 0;

        // Reset and quiescent stability
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_txd", txd, 1);
        chk("rst_ready", dispatch_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_idle", tx_idle, 1);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("rst_stable", {txd, dispatch_ready, tx_idle, fifo_count}, {3'b111, 5'd0});
        end

        // Single byte 0xA5
        dispatch_valid = 1'b1;
        dispatch_data  = 32'h0000_00A5;
        exp_q.push_back(8'hA5);
        tick();
        dispatch_valid = 1'b0;
        chk("a5_count", fifo_count, 1);
        chk("a5_idle_drop", tx_idle, 0);
        chk("a5_txd_pre", txd, 1);
        tick();
        chk("a5_txd_fall", txd, 0);
        chk("a5_popped", fifo_count, 0);
        wait_idle(200, n);
        chk("a5_frame_len", n, 40);

        // Upper bits ignored
        dispatch_valid = 1'b1;
        dispatch_data  = 32'hDEAD_BE41;
        exp_q.push_back(8'h41);
        tick();
        dispatch_valid = 1'b0;
        wait_idle(200, n);
        chk("x41_len", n, 41);

        // Back-to-back frames
        starts.delete();
        dispatch_valid = 1'b1;
        dispatch_data  = 32'h0000_0000;
        exp_q.push_back(8'h00);
        tick();
        chk("b2b_cnt1", fifo_count, 1);
        dispatch_data = 32'h0000_00FF;
        exp_q.push_back(8'hFF);
        tick();
        dispatch_valid = 1'b0;
        chk("b2b_cnt2", fifo_count, 1);
        repeat (39) tick();
        chk("b2b_cnt_hold", fifo_count, 1);
        tick();
        chk("b2b_cnt3", fifo_count, 0);
        chk("b2b_start2", txd, 0);
        wait_idle(200, n);
        chk("b2b_tail", n, 40);
        chk("b2b_frames", starts.size(), 2);
        if (starts.size() == 2)
            chk("b2b_gap", starts[1] - starts[0], 40);

        // Full FIFO: stream 0..20 with valid held high
        for (int i = 0; i <= 20; i++) begin
            dispatch_valid = 1'b1;
            dispatch_data  = 32'(i);
            if (i == 17) begin
                chk("full_count", fifo_count, 16);
                chk("full_ready", dispatch_ready, 0);
            end
            w = 0;
            while (dispatch_ready !== 1'b1 && w < 200) begin
                tick();
                w++;
            end
            exp_q.push_back(8'(i));
            tick();
            if (i == 0)  c0  = cyc;
            if (i == 17) c17 = cyc;
        end
        dispatch_valid = 1'b0;
        chk("full_b17_edge", c17 - c0, 42);
        wait_idle(2000, n);

        // Reset mid-frame with 5 bytes buffered
        for (int i = 0; i < 6; i++) begin
            dispatch_valid = 1'b1;
            dispatch_data  = 32'h10 + 32'(i);
            tick();
        end
        dispatch_valid = 1'b0;
        repeat (13) tick();
        chk("mid_count", fifo_count, 5);
        rst = 1'b1;
        tick();
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ready", dispatch_ready, 1);
        chk("mid_rst_idle", tx_idle, 1);
        rst = 1'b0;
        tick();
        dispatch_valid = 1'b1;
        dispatch_data  = 32'h0000_003C;
        exp_q.push_back(8'h3C);
        tick();
        dispatch_valid = 1'b0;
        wait_idle(200, n);
        chk("x3c_len", n, 41);

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
